mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequences all accesses to the single-ported unified memory, sharing it between instruction fetch and the LW/SW data path. Arbitrates by fixed data priority with a starvation guard for fetch, issues one access at a time, and tracks read latency to return data to the right requester. It sits between the fetch stage and the decode/execute control, and the memory macro.

## Interface

- ADDR_W, 11, memory address width (matches the 11-bit LW/SW address field)
- DATA_W, 32, memory data width
- MEM_LAT, 1, cycles from mem_en (read) to valid mem_rdata; legal range 1..7
- STARVE_MAX, 4, consecutive lost arbitrations after which fetch wins

Ports:

- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- if_req  in  1  fetch read request, held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  if_rdata valid this cycle
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = SW write, 0 = LW read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  d_rdata valid this cycle (reads only)
- d_rdata  out  DATA_W  data read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

## Operation

- FSM states: IDLE, READ_WAIT.
- IDLE: if any request is pending, grant exactly one requester. The grant and the mem_* outputs are combinational from the winner in the same cycle.
  - Granted read: go to READ_WAIT, latency counter = MEM_LAT-1, owner recorded.
  - Granted write: stay in IDLE.
- READ_WAIT: no grants. The counter decrements each cycle. At count 0, assert rvalid to the owner and return to IDLE.
- Priority: data beats fetch, unless starve_cnt == STARVE_MAX, in which case fetch wins.
- starve_cnt:
  - increments when both requests are pending and data wins;
  - clears on any fetch grant;
  - saturates at STARVE_MAX.
- Only one access is in flight. Writes get no rvalid.
- if_rdata and d_rdata both pass mem_rdata through. They are qualified only by their own rvalid.
- Requester rules:
  - A requester must hold req and its address/data stable until gnt.
  - Dropping req before gnt is legal and is simply not serviced.

## Timing

- Reset values, while reset is high and one cycle after release: state IDLE, starve_cnt 0, owner none. if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en and mem_we are 0. mem_addr and mem_wdata are 0.
- Read granted in cycle N: rvalid is in cycle N+MEM_LAT. In that rvalid cycle the FSM is back in IDLE and can grant again (zero-bubble back-to-back reads).
- Write granted in cycle N: the next grant is possible in cycle N+1.
- Simultaneous if_req and d_req in IDLE: exactly one gnt. The loser sees gnt=0 and keeps requesting.
- Request arriving during READ_WAIT: waits. If it is a fetch loss against data, it does not increment starve_cnt.
- Reset asserted mid-READ_WAIT: the access is abandoned and no rvalid is issued after reset.

## Configuration

- MEM_ARB_STATS_EN defined: adds three 16-bit saturating counters, each cleared by reset:
  - stat_if_cnt: fetch grants;
  - stat_d_cnt: data grants;
  - stat_conflict_cnt: IDLE cycles with both requests pending.
- Adds output ports stat_if_cnt, stat_d_cnt and stat_conflict_cnt, each 16 bits.
- Not defined: no counters and no stat ports; the rest of the behaviour is identical.

## Structure

- Shared package mem_arb_pkg holds:
  - state enum: IDLE, READ_WAIT;
  - owner encoding: OWN_NONE, OWN_IF, OWN_D;
  - the latency counter width constant (3 bits).
- One natural sub-module: mem_arb_stats, holding the counters. It is instantiated only under MEM_ARB_STATS_EN.

## Test plan

- Reset: drive requests with reset high. Required: all gnt/rvalid/mem_en are 0; after release, the first request is granted in its first IDLE cycle.
- Lone fetch at 0x005, MEM_LAT=1, mem_rdata=0xDEADBEEF: if_gnt and mem_en in cycle N with mem_addr 0x005; if_rvalid=1 with if_rdata 0xDEADBEEF in N+1.
- Simultaneous fetch 0x010 and SW to 0x020 with data 0x7: d_gnt with mem_we=1 and mem_wdata 0x7 in cycle N; if_gnt in N+1.
- Starvation, STARVE_MAX=4: d_req held continuously with LW/SW mix, plus if_req held. Required: four data grants, then if_gnt on the fifth arbitration.
- MEM_LAT=3, back-to-back LW: rvalid in N+3, second d_gnt in N+3, second rvalid in N+6.
- Reset asserted in READ_WAIT: no d_rvalid afterwards; state is IDLE; with MEM_ARB_STATS_EN the counters read 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : mem_arb_pkg
// Brief    : Shared types and constants for the unified-memory port arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

    // Width of the read-latency down-counter (covers MEM_LAT up to 7)
    localparam int unsigned c_LAT_W = 3;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        READ_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_stats.sv
//------------------------------------------------------------------------------
// Module   : mem_arb_stats
// Brief    : Saturating 16-bit activity counters for the memory port arbiter
//            (fetch grants, data grants, contested arbitration cycles).
//            Present only when MEM_ARB_STATS_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_arb_stats (
    input  logic        clock,
    input  logic        reset,
    input  logic        inc_if,
    input  logic        inc_d,
    input  logic        inc_conflict,
    output logic [15:0] stat_if_cnt,
    output logic [15:0] stat_d_cnt,
    output logic [15:0] stat_conflict_cnt
);

    localparam logic [15:0] c_SAT = 16'hFFFF;

    logic [15:0] r_if_cnt;
    logic [15:0] r_d_cnt;
    logic [15:0] r_conflict_cnt;

    // Count events, holding each counter at all-ones once it saturates
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_if_cnt       <= '0;
            r_d_cnt        <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (inc_if && (r_if_cnt != c_SAT))
                r_if_cnt <= r_if_cnt + 16'd1;
            if (inc_d && (r_d_cnt != c_SAT))
                r_d_cnt <= r_d_cnt + 16'd1;
            if (inc_conflict && (r_conflict_cnt != c_SAT))
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign stat_if_cnt       = r_if_cnt;
    assign stat_d_cnt        = r_d_cnt;
    assign stat_conflict_cnt = r_conflict_cnt;

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : mem_port_arbiter
// Brief    : Shares the single-ported unified memory between instruction fetch
//            and the LW/SW data path. Data has fixed priority; a starvation
//            counter lets fetch win after STARVE_MAX consecutive losses. One
//            access in flight; read data is steered by a latency counter.
//            Optional statistics counters: define MEM_ARB_STATS_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
   ,output logic [15:0]       stat_if_cnt,
    output logic [15:0]       stat_d_cnt,
    output logic [15:0]       stat_conflict_cnt
`endif
);

    localparam int unsigned       c_STARVE_W   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [c_LAT_W-1:0] c_LAT_INIT  = c_LAT_W'(MEM_LAT - 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_SAT = c_STARVE_W'(STARVE_MAX);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [c_LAT_W-1:0]      r_lat_cnt;
    logic [c_LAT_W-1:0]      w_lat_cnt_nxt;
    owner_t                  r_owner;
    owner_t                  w_owner_nxt;
    logic [c_STARVE_W-1:0]   r_starve_cnt;

    logic w_read_done;
    logic w_arb_en;
    logic w_if_win;
    logic w_d_win;

    // Arbitration: the final READ_WAIT cycle also arbitrates so back-to-back
    // reads run without a bubble; reset masks every grant combinationally.
    always_comb begin
        w_read_done = (r_state == READ_WAIT) && (r_lat_cnt == '0);
        w_arb_en    = !reset && ((r_state == IDLE) || w_read_done);
        w_if_win    = w_arb_en && if_req && (!d_req || (r_starve_cnt == c_STARVE_SAT));
        w_d_win     = w_arb_en && d_req && !w_if_win;

        if_gnt    = w_if_win;
        d_gnt     = w_d_win;
        mem_en    = w_if_win || w_d_win;
        mem_we    = w_d_win && d_we;
        mem_addr  = w_if_win ? if_addr : (w_d_win ? d_addr : '0);
        mem_wdata = w_d_win ? d_wdata : '0;

        if_rvalid = w_read_done && (r_owner == OWN_IF);
        d_rvalid  = w_read_done && (r_owner == OWN_D);
        if_rdata  = mem_rdata;
        d_rdata   = mem_rdata;
    end

    // Next-state: a granted read loads the latency counter and records its owner
    always_comb begin
        w_state_nxt   = r_state;
        w_lat_cnt_nxt = r_lat_cnt;
        w_owner_nxt   = r_owner;
        if (w_if_win || (w_d_win && !d_we)) begin
            w_state_nxt   = READ_WAIT;
            w_lat_cnt_nxt = c_LAT_INIT;
            w_owner_nxt   = w_if_win ? OWN_IF : OWN_D;
        end else if (w_arb_en || w_read_done) begin
            w_state_nxt   = IDLE;
            w_lat_cnt_nxt = '0;
            w_owner_nxt   = OWN_NONE;
        end else if (r_state == READ_WAIT) begin
            w_lat_cnt_nxt = r_lat_cnt - c_LAT_W'(1);
        end
    end

    // FSM state, latency counter and owner registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_lat_cnt <= '0;
            r_owner   <= OWN_NONE;
        end else begin
            r_state   <= w_state_nxt;
            r_lat_cnt <= w_lat_cnt_nxt;
            r_owner   <= w_owner_nxt;
        end
    end

    // Starvation guard: counts contested arbitrations fetch lost, cleared by any fetch grant
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_if_win) begin
            r_starve_cnt <= '0;
        end else if (w_d_win && if_req && (r_starve_cnt != c_STARVE_SAT)) begin
            r_starve_cnt <= r_starve_cnt + c_STARVE_W'(1);
        end
    end

`ifdef MEM_ARB_STATS_EN
    mem_arb_stats u_stats (
        .clock             (clock),
        .reset             (reset),
        .inc_if            (w_if_win),
        .inc_d             (w_d_win),
        .inc_conflict      (w_arb_en && if_req && d_req),
        .stat_if_cnt       (stat_if_cnt),
        .stat_d_cnt        (stat_d_cnt),
        .stat_conflict_cnt (stat_conflict_cnt)
    );
`endif

endmodule

`default_nettype wire
